// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic unit: ALU_FUN codes, divider states and
// parameter sanity checks.
package arith_pkg;

  localparam logic [1:0] ARITH_ADD = 2'b00;
  localparam logic [1:0] ARITH_SUB = 2'b01;
  localparam logic [1:0] ARITH_MUL = 2'b10;
  localparam logic [1:0] ARITH_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} div_state_t;

  function automatic bit widths_ok(int in_w, int out_w);
    return (in_w >= 4) && (out_w == 2 * in_w);
  endfunction

endpackage

// File: rtl/arith_unit_mc_if.sv
// Request/result bundle of the arithmetic unit; master issues requests, slave is the unit.
interface arith_unit_mc_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
);
  logic signed [IN_WIDTH-1:0]  A;
  logic signed [IN_WIDTH-1:0]  B;
  logic [1:0]                  ALU_FUN;
  logic                        Arith_Enable;
  logic                        Busy;
  logic signed [OUT_WIDTH-1:0] Arith_OUT;
  logic                        Carry_OUT;
  logic                        Overflow;
  logic                        Div_Zero;
  logic                        Arith_Flag;

  modport master (
    output A, B, ALU_FUN, Arith_Enable,
    input  Busy, Arith_OUT, Carry_OUT, Overflow, Div_Zero, Arith_Flag
  );

  modport slave (
    input  A, B, ALU_FUN, Arith_Enable,
    output Busy, Arith_OUT, Carry_OUT, Overflow, Div_Zero, Arith_Flag
  );
endinterface

// File: rtl/arith_seq_div.sv
// Iterative signed restoring divider, truncating toward zero. With ARITH_SAT_EN defined,
// MIN / -1 returns quotient MAX instead of MIN.
module arith_seq_div import arith_pkg::*; #(
  parameter int IN_WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [IN_WIDTH-1:0] quot,
  output logic [IN_WIDTH-1:0] rem,
  output logic                dz,
  output logic                ovf
);
  localparam int N    = IN_WIDTH;
  localparam int CntW = $clog2(IN_WIDTH);
  localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};

  div_state_t      state_q, state_d;
  logic [N-1:0]    a_q, b_q, quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    abs_a, abs_b, src_rem, src_quot, dvs_cur, step_rem, step_quot;
  logic [N:0]      sh, trial;

  assign dz    = (b == '0);
  assign abs_a = a_q[N-1] ? -a_q : a_q;
  assign abs_b = b_q[N-1] ? -b_q : b_q;

  // LOAD performs the first restoring step straight from the magnitudes, ITER does the rest.
  assign src_rem   = (state_q == LOAD) ? '0    : rem_q;
  assign src_quot  = (state_q == LOAD) ? abs_a : quot_q;
  assign dvs_cur   = (state_q == LOAD) ? abs_b : dvs_q;
  assign sh        = {src_rem, src_quot[N-1]};
  assign trial     = sh - {1'b0, dvs_cur};
  assign step_rem  = trial[N] ? sh[N-1:0] : trial[N-1:0];
  assign step_quot = {src_quot[N-2:0], ~trial[N]};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start && !dz) state_d = LOAD;
      LOAD: begin
        rem_d   = step_rem;
        quot_d  = step_quot;
        dvs_d   = abs_b;
        cnt_d   = CntW'(N - 2);
        state_d = ITER;
      end
      ITER: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && start && !dz) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIX);
  assign ovf  = (a_q == MinVal) && (b_q == '1);

  // The magnitude of MIN / -1 is 2^(N-1), which already reads back as MIN when wrapping.
  always_comb begin
    quot = (a_q[N-1] ^ b_q[N-1]) ? -quot_q : quot_q;
    rem  = a_q[N-1] ? -rem_q : rem_q;
`ifdef ARITH_SAT_EN
    if (ovf) quot = {1'b0, {(N-1){1'b1}}};
`endif
  end

endmodule

// File: rtl/arith_unit_mc.sv
// Signed ADD/SUB/MUL in one cycle and iterative DIV behind a valid/busy handshake.
// Define ARITH_SAT_EN to saturate ADD/SUB on signed overflow instead of wrapping.
module arith_unit_mc import arith_pkg::*; #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
  input logic            CLK,
  input logic            RST,
  arith_unit_mc_if.slave bus
);
  localparam int N = IN_WIDTH;

  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_width_chk
    $error("arith_unit_mc: need IN_WIDTH >= 4 and OUT_WIDTH == 2*IN_WIDTH");
  end

  logic                 accept, div_start, div_busy, div_done, div_dz, div_ovf;
  logic [N-1:0]         div_quot, div_rem, add_res, sub_res;
  logic [N:0]           add_sum, sub_diff;
  logic                 add_ovf, sub_ovf;
  logic signed [OUT_WIDTH-1:0] a_ext, b_ext, prod;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d, flag_q, flag_d;

  assign accept   = bus.Arith_Enable && !div_busy;
  assign add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_diff = {1'b0, bus.A} - {1'b0, bus.B};
  assign add_ovf  = (bus.A[N-1] == bus.B[N-1]) && (add_sum[N-1] != bus.A[N-1]);
  assign sub_ovf  = (bus.A[N-1] != bus.B[N-1]) && (sub_diff[N-1] != bus.A[N-1]);

`ifdef ARITH_SAT_EN
  // Overflow direction always follows the sign of A for both ADD and SUB.
  assign add_res = add_ovf ? {bus.A[N-1], {(N-1){~bus.A[N-1]}}} : add_sum[N-1:0];
  assign sub_res = sub_ovf ? {bus.A[N-1], {(N-1){~bus.A[N-1]}}} : sub_diff[N-1:0];
`else
  assign add_res = add_sum[N-1:0];
  assign sub_res = sub_diff[N-1:0];
`endif

  assign a_ext = $signed({{(OUT_WIDTH-N){bus.A[N-1]}}, bus.A});
  assign b_ext = $signed({{(OUT_WIDTH-N){bus.B[N-1]}}, bus.B});
  assign prod  = a_ext * b_ext;

  arith_seq_div #(.IN_WIDTH(IN_WIDTH)) u_div (
    .CLK   (CLK),
    .RST   (RST),
    .start (div_start),
    .a     (bus.A),
    .b     (bus.B),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem),
    .dz    (div_dz),
    .ovf   (div_ovf)
  );

  always_comb begin
    out_d     = out_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    flag_d    = 1'b0;
    div_start = 1'b0;
    if (div_done) begin
      out_d   = {div_rem, div_quot};
      carry_d = 1'b0;
      ovf_d   = div_ovf;
      dz_d    = 1'b0;
      flag_d  = 1'b1;
    end else if (accept) begin
      unique case (bus.ALU_FUN)
        ARITH_ADD: begin
          out_d   = {{N{add_res[N-1]}}, add_res};
          carry_d = add_sum[N];
          ovf_d   = add_ovf;
          dz_d    = 1'b0;
          flag_d  = 1'b1;
        end
        ARITH_SUB: begin
          out_d   = {{N{sub_res[N-1]}}, sub_res};
          carry_d = sub_diff[N];
          ovf_d   = sub_ovf;
          dz_d    = 1'b0;
          flag_d  = 1'b1;
        end
        ARITH_MUL: begin
          out_d   = prod;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          flag_d  = 1'b1;
        end
        ARITH_DIV: begin
          div_start = 1'b1;
          // Divide-by-zero never enters the divider and completes like a one-cycle op.
          if (div_dz) begin
            out_d   = {bus.A, {N{1'b1}}};
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
            flag_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.Busy       = div_busy;
  assign bus.Arith_OUT  = out_q;
  assign bus.Carry_OUT  = carry_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Div_Zero   = dz_q;
  assign bus.Arith_Flag = flag_q;

endmodule

// File: tb/tb_arith_unit_mc.sv
// Self-checking bench for arith_unit_mc (IN_WIDTH=16): directed cases plus a random stream
// checked against a scoreboard fed by an independent integer model.
module tb_arith_unit_mc;
  import arith_pkg::*;

  typedef struct {
    logic [34:0] res;  // {Arith_OUT, Carry_OUT, Overflow, Div_Zero}
    int          due;  // edge index after which Arith_Flag must be high
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [34:0] hold = '0;
  int   free_edge = 0;
  int   busy_from = 0;
  int   busy_to = -1;

  arith_unit_mc_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus ();

  arith_unit_mc #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] model(input logic [1:0] f, input logic signed [15:0] a,
                                        input logic signed [15:0] b);
    int ia, ib, ua, ub, s, q, r;
    logic [15:0] r16;
    logic c, v;
    ia = a;
    ib = b;
    ua = {16'h0, a};
    ub = {16'h0, b};
    case (f)
      ARITH_ADD, ARITH_SUB: begin
        s = (f == ARITH_ADD) ? ia + ib : ia - ib;
        c = (f == ARITH_ADD) ? (ua + ub > 65535) : (ua < ub);
        v = (s > 32767) || (s < -32768);
        r16 = s[15:0];
`ifdef ARITH_SAT_EN
        if (v) r16 = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {{16{r16[15]}}, r16, c, v, 1'b0};
      end
      ARITH_MUL: begin
        s = ia * ib;
        return {s, 3'b000};
      end
      default: begin
        if (ib == 0) return {a, 16'hFFFF, 3'b001};
        if (ia == -32768 && ib == -1) begin
`ifdef ARITH_SAT_EN
          return {16'h0000, 16'h7FFF, 3'b010};
`else
          return {16'h0000, 16'h8000, 3'b010};
`endif
        end
        q = ia / ib;
        r = ia % ib;
        return {r[15:0], q[15:0], 3'b000};
      end
    endcase
  endfunction

  // Drive a request for the coming edge and predict whether the DUT takes it.
  task automatic req(input logic [1:0] f, input logic signed [15:0] a,
                     input logic signed [15:0] b);
    int e;
    exp_t x;
    bus.ALU_FUN = f;
    bus.A = a;
    bus.B = b;
    bus.Arith_Enable = 1'b1;
    e = cyc + 1;
    if (e >= free_edge) begin
      x.res = model(f, a, b);
      if (f == ARITH_DIV && b != 0) begin
        x.due = e + 17;
        busy_from = e;
        busy_to = e + 16;
        free_edge = e + 18;
      end else begin
        x.due = e;
        free_edge = e + 1;
      end
      sb.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.Arith_Enable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    sb.delete();
    hold = '0;
    busy_from = 0;
    busy_to = -1;
    free_edge = cyc + 1;
    rst = 1'b0;
  endtask

  task automatic wait_flag();
    int n;
    n = 0;
    while (!bus.Arith_Flag && n < 40) begin
      tick();
      n++;
    end
    chk("flag_timeout", 35'(n < 40), 35'(1));
  endtask

  function automatic logic signed [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'sh8000;
      1:       return 16'sh7FFF;
      2:       return -16'sd1;
      3:       return 16'($signed($urandom_range(0, 20)) - 10);
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: Busy, Arith_Flag timing and held outputs every cycle against the model.
  initial begin
    logic exp_busy, exp_flag;
    forever begin
      @(negedge clk);
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      chk("busy", 35'(bus.Busy), 35'(exp_busy));
      exp_flag = (sb.size() > 0) && (sb[0].due == cyc);
      chk("flag", 35'(bus.Arith_Flag), 35'(exp_flag));
      if (exp_flag) begin
        hold = sb[0].res;
        void'(sb.pop_front());
      end
      chk("result", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero}, hold);
    end
  end

  initial begin
    int n, busy_cnt;
    logic [1:0] f;
    logic signed [15:0] a, b;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_FUN = ARITH_ADD;
    bus.Arith_Enable = 1'b0;
    repeat (2) tick();
    do_reset();
    chk("reset_out", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero}, 35'(0));
    chk("reset_ctl", 35'({bus.Arith_Flag, bus.Busy}), 35'(0));

    req(ARITH_ADD, 16'sh7FFF, 16'sh0001);
    tick();
`ifdef ARITH_SAT_EN
    chk("add_ovf", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'h00007FFF, 3'b010});
`else
    chk("add_ovf", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'hFFFF8000, 3'b010});
`endif
    chk("add_flag", 35'(bus.Arith_Flag), 35'(1));

    // Back-to-back one-cycle ops.
    req(ARITH_SUB, 16'sh0000, 16'sh0001);
    tick();
    chk("sub_borrow", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'hFFFFFFFF, 3'b100});
    req(ARITH_MUL, -16'sd3, 16'sd5);
    tick();
    chk("mul_neg", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'hFFFFFFF1, 3'b000});
    chk("mul_flag", 35'(bus.Arith_Flag), 35'(1));

    // DIV -7/2 with a dropped request in the middle.
    req(ARITH_DIV, -16'sd7, 16'sd2);
    tick();
    n = 1;
    busy_cnt = 0;
    while (!bus.Arith_Flag && n < 40) begin
      if (bus.Busy) busy_cnt++;
      if (n == 5) req(ARITH_ADD, 16'sd1, 16'sd1);
      tick();
      n++;
    end
    chk("div_latency", 35'(n), 35'(18));
    chk("div_busy_len", 35'(busy_cnt), 35'(17));
    chk("div_busy_fall", 35'(bus.Busy), 35'(0));
    chk("div_neg", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'hFFFFFFFD, 3'b000});

    req(ARITH_DIV, 16'sd100, 16'sd0);
    tick();
    chk("div_zero", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'h0064FFFF, 3'b001});
    chk("div_zero_ctl", 35'({bus.Arith_Flag, bus.Busy}), 35'(2'b10));

    req(ARITH_DIV, 16'sh8000, 16'shFFFF);
    tick();
    wait_flag();
`ifdef ARITH_SAT_EN
    chk("div_min", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'h00007FFF, 3'b010});
`else
    chk("div_min", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'h00008000, 3'b010});
`endif

    // Reset in cycle 5 of a DIV aborts it silently.
    tick();
    req(ARITH_DIV, 16'sd1000, 16'sd3);
    tick();
    repeat (4) tick();
    do_reset();
    chk("rst_abort_out", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero}, 35'(0));
    chk("rst_abort_ctl", 35'({bus.Arith_Flag, bus.Busy}), 35'(0));
    req(ARITH_ADD, 16'sd2, 16'sd3);
    tick();
    chk("add_after_rst", {bus.Arith_OUT, bus.Carry_OUT, bus.Overflow, bus.Div_Zero},
        {32'h00000005, 3'b000});
    chk("add_after_rst_flag", 35'(bus.Arith_Flag), 35'(1));
    repeat (25) tick();

    for (int i = 0; i < 400; i++) begin
      f = 2'($urandom_range(0, 3));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 16'sd0 : pick();
      if ($urandom_range(0, 3) != 0) req(f, a, b);
      tick();
    end
    repeat (25) tick();
    chk("drain", 35'(sb.size()), 35'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
